// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin arbiter sharing one AXI-style read port (AR + R channels).
// Optional burst-length check enabled by defining AXI_RD_ARB_RLAST_CHK_EN.
module axi_rd_arbiter #(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 128,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] m0_araddr,
   input  logic          m0_arvalid,
   output logic          m0_arready,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   output logic          m0_rlast,
   input  logic          m0_rready,
   input  logic [AW-1:0] m1_araddr,
   input  logic          m1_arvalid,
   output logic          m1_arready,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   output logic          m1_rlast,
   input  logic          m1_rready,
   output logic [AW-1:0] s_araddr,
   output logic          s_arvalid,
   input  logic          s_arready,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_rvalid,
   input  logic          s_rlast,
   output logic          s_rready,
   output logic          grant,
   output logic          busy,
   output logic          err_rlast
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_grant;
   logic   w_grant_nxt;
   logic   w_s_arvalid;
   logic   w_s_rready;
   logic   w_m0_arready, w_m1_arready;
   logic   w_m0_rvalid, w_m1_rvalid;
   logic   w_m0_rlast, w_m1_rlast;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_s_arvalid  = 1'b0;
      w_s_rready   = 1'b0;
      w_m0_arready = 1'b0;
      w_m1_arready = 1'b0;
      w_m0_rvalid  = 1'b0;
      w_m1_rvalid  = 1'b0;
      w_m0_rlast   = 1'b0;
      w_m1_rlast   = 1'b0;
      case (r_state)
         IDLE: begin
            // On contention the master that was not served last wins.
            if (m0_arvalid && m1_arvalid) begin
               w_grant_nxt = ~r_grant;
               w_state_nxt = ADDR;
            end else if (m0_arvalid) begin
               w_grant_nxt = 1'b0;
               w_state_nxt = ADDR;
            end else if (m1_arvalid) begin
               w_grant_nxt = 1'b1;
               w_state_nxt = ADDR;
            end
         end
         ADDR: begin
            w_s_arvalid  = 1'b1;
            w_m0_arready = !r_grant && s_arready;
            w_m1_arready = r_grant && s_arready;
            if (s_arready) w_state_nxt = DATA;
         end
         DATA: begin
            w_s_rready  = r_grant ? m1_rready : m0_rready;
            w_m0_rvalid = !r_grant && s_rvalid;
            w_m1_rvalid = r_grant && s_rvalid;
            w_m0_rlast  = !r_grant && s_rlast;
            w_m1_rlast  = r_grant && s_rlast;
            if (s_rvalid && w_s_rready && s_rlast) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign s_araddr   = r_grant ? m1_araddr : m0_araddr;
   assign s_arvalid  = w_s_arvalid;
   assign s_rready   = w_s_rready;
   assign m0_arready = w_m0_arready;
   assign m1_arready = w_m1_arready;
   assign m0_rvalid  = w_m0_rvalid;
   assign m1_rvalid  = w_m1_rvalid;
   assign m0_rlast   = w_m0_rlast;
   assign m1_rlast   = w_m1_rlast;
   assign m0_rdata   = s_rdata;
   assign m1_rdata   = s_rdata;
   assign grant      = r_grant;
   assign busy       = (r_state != IDLE);

`ifdef AXI_RD_ARB_RLAST_CHK_EN
   localparam int unsigned CW = $clog2(BURST_LEN) + 1;

   logic [CW-1:0] r_beat_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_ar_hs;
   logic          w_r_hs;
   logic          r_err;

   assign w_ar_hs   = (r_state == ADDR) && s_arready;
   assign w_r_hs    = (r_state == DATA) && s_rvalid && w_s_rready;
   assign w_cnt_inc = r_beat_cnt + 1'b1;

   // Error when rlast disagrees with this beat being beat BURST_LEN; counter saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_ar_hs) r_beat_cnt <= '0;
         else if (w_r_hs && !(&r_beat_cnt)) r_beat_cnt <= w_cnt_inc;
         if (w_r_hs && (s_rlast != (w_cnt_inc == CW'(BURST_LEN)))) r_err <= 1'b1;
      end
   end

   assign err_rlast = r_err;
`else
   logic w_unused_burst_len;
   assign w_unused_burst_len = (BURST_LEN != 0);
   assign err_rlast          = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;
`ifdef AXI_RD_ARB_RLAST_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic          m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic          s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic          grant, busy, err_rlast;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_beats [2];
  int mon_beats [2];
  int exp_last;

  axi_rd_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
    .grant(grant), .busy(busy), .err_rlast(err_rlast)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m0_rvalid && m0_rready) mon_beats[0]++;
    if (m1_rvalid && m1_rready) mon_beats[1]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input int m, input logic v, input logic [AW-1:0] a);
    if (m == 0) begin m0_arvalid = v; m0_araddr = a; end
    else        begin m1_arvalid = v; m1_araddr = a; end
  endtask

  task automatic set_rr(input int m, input logic v);
    if (m == 0) m0_rready = v;
    else        m1_rready = v;
  endtask

  function automatic int rr_pick(input int last, input logic r0, input logic r1);
    if (r0 && r1) return 1 - last;
    if (r0)       return 0;
    return 1;
  endfunction

  task automatic do_burst(input int unsigned nbeats, input bit hold3, input bit reissue);
    int            g;
    int            k;
    logic          gb;
    logic [1:0]    gmask;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = rr_pick(exp_last, m0_arvalid, m1_arvalid);
    gb = (g == 1);
    gmask = gb ? 2'b10 : 2'b01;
    a = gb ? m1_araddr : m0_araddr;
    smp();
    n_checks++; if (busy === 1'b0) n_pass++; else $error("FAIL idle_busy: 0x%0h", busy);
    n_checks++; if (s_arvalid === 1'b0) n_pass++; else $error("FAIL idle_s_arvalid: 0x%0h", s_arvalid);
    n_checks++; if ({m1_arready, m0_arready} === 2'b00) n_pass++; else $error("FAIL idle_arready: 0x%0h", {m1_arready, m0_arready});
    adv();
    exp_last = g;
    k = $urandom_range(0, 2);
    repeat (k) begin
      smp();
      n_checks++; if (s_arvalid === 1'b1) n_pass++; else $error("FAIL addr_s_arvalid: 0x%0h", s_arvalid);
      n_checks++; if (s_araddr === a) n_pass++; else $error("FAIL addr_araddr: 0x%0h exp 0x%0h", s_araddr, a);
      n_checks++; if (grant === gb) n_pass++; else $error("FAIL addr_grant: 0x%0h exp 0x%0h", grant, gb);
      n_checks++; if (busy === 1'b1) n_pass++; else $error("FAIL addr_busy: 0x%0h", busy);
      n_checks++; if ({m1_arready, m0_arready} === 2'b00) n_pass++; else $error("FAIL addr_arready_wait: 0x%0h", {m1_arready, m0_arready});
      adv();
    end
    s_arready = 1'b1;
    smp();
    n_checks++; if (s_araddr === a) n_pass++; else $error("FAIL hs_araddr: 0x%0h exp 0x%0h", s_araddr, a);
    n_checks++; if ({m1_arready, m0_arready} === gmask) n_pass++; else $error("FAIL hs_arready: 0x%0h exp 0x%0h", {m1_arready, m0_arready}, gmask);
    adv();
    s_arready = 1'b0;
    if (reissue) set_ar(g, 1'b1, $urandom());
    else         set_ar(g, 1'b0, '0);
    for (int unsigned b = 0; b < nbeats; b++) begin
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      k = $urandom_range(0, 2);
      repeat (k) begin
        smp();
        n_checks++; if ({m1_rvalid, m0_rvalid} === 2'b00) n_pass++; else $error("FAIL gap_rvalid: 0x%0h", {m1_rvalid, m0_rvalid});
        n_checks++; if (busy === 1'b1) n_pass++; else $error("FAIL gap_busy: 0x%0h", busy);
        adv();
      end
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rlast  = (b == nbeats - 1);
      set_rr(g, 1'b0);
      set_rr(1 - g, 1'($urandom_range(0, 1)));
      k = (hold3 && b == 0) ? 3 : $urandom_range(0, 1);
      repeat (k) begin
        smp();
        n_checks++; if (s_rready === 1'b0) n_pass++; else $error("FAIL hold_s_rready: 0x%0h", s_rready);
        n_checks++; if ({m1_rvalid, m0_rvalid} === gmask) n_pass++; else $error("FAIL hold_rvalid: 0x%0h exp 0x%0h", {m1_rvalid, m0_rvalid}, gmask);
        adv();
      end
      set_rr(g, 1'b1);
      smp();
      n_checks++; if (s_rready === 1'b1) n_pass++; else $error("FAIL beat_s_rready: 0x%0h", s_rready);
      n_checks++; if ({m1_rvalid, m0_rvalid} === gmask) n_pass++; else $error("FAIL beat_rvalid: 0x%0h exp 0x%0h", {m1_rvalid, m0_rvalid}, gmask);
      n_checks++;
      if ({m1_rlast, m0_rlast} === ((b == nbeats - 1) ? gmask : 2'b00)) n_pass++;
      else $error("FAIL beat_rlast: 0x%0h", {m1_rlast, m0_rlast});
      n_checks++; if ((gb ? m1_rdata : m0_rdata) === d) n_pass++; else $error("FAIL beat_rdata: exp 0x%0h", d);
      n_checks++; if ({m1_arready, m0_arready} === 2'b00) n_pass++; else $error("FAIL beat_arready: 0x%0h", {m1_arready, m0_arready});
      adv();
      exp_beats[g]++;
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
  endtask

  initial begin
    exp_beats[0] = 0; exp_beats[1] = 0;
    mon_beats[0] = 0; mon_beats[1] = 0;
    set_ar(0, 1'b0, '0);
    set_ar(1, 1'b0, '0);
    m0_rready = 1'b1; m1_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = '0;

    rst = 1'b1;
    adv(); adv();
    smp();
    n_checks++; if (busy === 1'b0) n_pass++; else $error("FAIL rst_busy: 0x%0h", busy);
    n_checks++; if (grant === 1'b1) n_pass++; else $error("FAIL rst_grant: 0x%0h", grant);
    n_checks++; if (err_rlast === 1'b0) n_pass++; else $error("FAIL rst_err: 0x%0h", err_rlast);
    n_checks++; if (s_arvalid === 1'b0) n_pass++; else $error("FAIL rst_s_arvalid: 0x%0h", s_arvalid);
    n_checks++; if (s_rready === 1'b0) n_pass++; else $error("FAIL rst_s_rready: 0x%0h", s_rready);
    n_checks++; if ({m1_rvalid, m0_rvalid} === 2'b00) n_pass++; else $error("FAIL rst_rvalid: 0x%0h", {m1_rvalid, m0_rvalid});
    adv();
    rst = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b0;
    exp_last = 1;
    smp();
    n_checks++; if (s_rready === 1'b0) n_pass++; else $error("FAIL idle_s_rready: 0x%0h", s_rready);
    adv();

    set_ar(0, 1'b1, 32'h10);
    do_burst(4, 1'b0, 1'b0);
    n_checks++; if (grant === 1'b0) n_pass++; else $error("FAIL single_grant: 0x%0h", grant);

    rst = 1'b1; adv(); rst = 1'b0; exp_last = 1;
    set_ar(0, 1'b1, $urandom());
    set_ar(1, 1'b1, $urandom());
    do_burst(4, 1'b0, 1'b0);
    n_checks++; if (grant === 1'b0) n_pass++; else $error("FAIL contend_first: 0x%0h", grant);
    do_burst(4, 1'b0, 1'b0);
    n_checks++; if (grant === 1'b1) n_pass++; else $error("FAIL contend_second: 0x%0h", grant);

    set_ar(0, 1'b1, $urandom());
    set_ar(1, 1'b1, $urandom());
    for (int unsigned i = 0; i < 4; i++) begin
      do_burst(4, 1'b0, 1'b1);
      n_checks++; if (grant === 1'(i % 2)) n_pass++; else $error("FAIL rr_alternate: 0x%0h at %0d", grant, i);
    end
    set_ar(0, 1'b0, '0);
    set_ar(1, 1'b0, '0);

    set_ar(0, 1'b1, $urandom());
    do_burst(4, 1'b1, 1'b0);
    n_checks++; if (mon_beats[0] == exp_beats[0]) n_pass++; else $error("FAIL beats_after_hold_m0: %0d exp %0d", mon_beats[0], exp_beats[0]);
    n_checks++; if (mon_beats[1] == exp_beats[1]) n_pass++; else $error("FAIL beats_after_hold_m1: %0d exp %0d", mon_beats[1], exp_beats[1]);
    n_checks++; if (err_rlast === 1'b0) n_pass++; else $error("FAIL err_clean: 0x%0h", err_rlast);

    set_ar(0, 1'b1, $urandom());
    smp(); adv();
    s_arready = 1'b1; smp(); adv();
    s_arready = 1'b0; set_ar(0, 1'b0, '0);
    s_rvalid = 1'b1; s_rdata = {4{$urandom()}}; m0_rready = 1'b1;
    smp();
    n_checks++; if (m0_rvalid === 1'b1) n_pass++; else $error("FAIL prerst_rvalid: 0x%0h", m0_rvalid);
    adv();
    s_rdata = {4{$urandom()}};
    rst = 1'b1;
    smp(); adv();
    rst = 1'b0;
    exp_beats[0] += 2;
    smp();
    n_checks++; if (busy === 1'b0) n_pass++; else $error("FAIL midrst_busy: 0x%0h", busy);
    n_checks++; if (s_rready === 1'b0) n_pass++; else $error("FAIL midrst_s_rready: 0x%0h", s_rready);
    n_checks++; if (grant === 1'b1) n_pass++; else $error("FAIL midrst_grant: 0x%0h", grant);
    n_checks++; if (m0_rvalid === 1'b0) n_pass++; else $error("FAIL midrst_rvalid: 0x%0h", m0_rvalid);
    adv();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    exp_last = 1;
    set_ar(1, 1'b1, $urandom());
    do_burst(4, 1'b0, 1'b0);
    n_checks++; if (grant === 1'b1) n_pass++; else $error("FAIL post_rst_grant: 0x%0h", grant);

    set_ar(0, 1'b1, $urandom());
    do_burst(2, 1'b0, 1'b0);
    n_checks++; if (err_rlast === EXP_ERR) n_pass++; else $error("FAIL err_after_short: 0x%0h", err_rlast);
    adv(); adv();
    n_checks++; if (err_rlast === EXP_ERR) n_pass++; else $error("FAIL err_sticky: 0x%0h", err_rlast);
    rst = 1'b1; adv(); rst = 1'b0;
    n_checks++; if (err_rlast === 1'b0) n_pass++; else $error("FAIL err_cleared: 0x%0h", err_rlast);

    n_checks++; if (mon_beats[0] == exp_beats[0]) n_pass++; else $error("FAIL beats_total_m0: %0d exp %0d", mon_beats[0], exp_beats[0]);
    n_checks++; if (mon_beats[1] == exp_beats[1]) n_pass++; else $error("FAIL beats_total_m1: %0d exp %0d", mon_beats[1], exp_beats[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master round-robin arbiter that shares one AXI-style read port (AR + R channels, 32-bit address, 128-bit data) in front of the AXI slave memory model.
- Grants one master at a time and forwards its address handshake to the slave.
- Routes read beats back to the granted master only, and holds the grant until the slave's RLAST beat completes.
- Sits between the test masters and the slave model in the bufferless-model unit-test bench.

Parameters:
- AW, 32, address width.
- DW, 128, data width.
- BURST_LEN, 4, expected beats per burst; used only by the optional check.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- m0_araddr  input  AW  master 0 read address.
- m0_arvalid  input  1  master 0 address valid.
- m0_arready  output  1  master 0 address ready.
- m0_rdata  output  DW  master 0 read data.
- m0_rvalid  output  1  master 0 read valid.
- m0_rlast  output  1  master 0 last beat.
- m0_rready  input  1  master 0 read ready.
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rvalid, m1_rlast, m1_rready: same directions, widths and meanings as the m0_* ports, for master 1.
- s_araddr  output  AW  slave address.
- s_arvalid  output  1  slave address valid.
- s_arready  input  1  slave address ready.
- s_rdata  input  DW  slave read data.
- s_rvalid  input  1  slave read valid.
- s_rlast  input  1  slave last beat.
- s_rready  output  1  slave read ready.
- grant  output  1  current or last granted master index.
- busy  output  1  high while state != IDLE.
- err_rlast  output  1  sticky burst-length error (optional feature only).

Behaviour:
- State machine IDLE -> ADDR -> DATA -> IDLE, state held in flops.
- Reset (sync, rst=1 at posedge):
  - state=IDLE, grant=1, so master 0 wins the first contention.
  - busy=0, err_rlast=0.
  - All valid/ready outputs are 0 combinationally once state=IDLE.
  - Reset mid-burst abandons the burst immediately: s_rready=0 from the next cycle, no further beats forwarded.
- IDLE:
  - s_arvalid=0, s_rready=0, both m*_arready=0, both m*_rvalid=0.
  - If exactly one m*_arvalid is high, that master is granted.
  - If both are high, the grant goes to the master != grant (round-robin).
  - On a grant, register grant and move to ADDR next cycle. Arbitration latency: 1 cycle from arvalid seen to s_arvalid.
- ADDR:
  - s_arvalid=1.
  - s_araddr = granted master's araddr, combinational mux. Masters hold araddr/arvalid stable until arready.
  - m[grant]_arready = s_arready; the other master's arready = 0.
  - On s_arvalid && s_arready, move to DATA.
- DATA:
  - s_rready = m[grant]_rready.
  - m[grant]_rvalid = s_rvalid; m[grant]_rlast = s_rlast.
  - The other master sees rvalid=0 and rlast=0.
  - Both m*_rdata = s_rdata (broadcast; qualified by rvalid).
  - A beat completes when s_rvalid && s_rready. On a completing beat with s_rlast=1, move to IDLE.
  - Back-to-back: a request pending in the IDLE cycle after release is granted then. Minimum 1 idle cycle between bursts.
- The other master's request is ignored outside IDLE; its arready stays 0, so its request is stalled, not lost.
- s_rvalid outside DATA is ignored: s_rready=0.
- grant is unchanged outside IDLE.
- No address arithmetic is done; araddr passes through unmodified.

Optional Feature:
- Macro: AXI_RD_ARB_RLAST_CHK_EN.
- When defined:
  - A beat counter (width clog2(BURST_LEN)+1) clears on entering DATA and increments per completed beat.
  - err_rlast sets (sticky until rst) if a completed beat has s_rlast=1 while count+1 != BURST_LEN.
  - err_rlast also sets if count reaches BURST_LEN without rlast.
  - Arbitration is unaffected; the arbiter still waits for rlast.
- When not defined: err_rlast is tied to 0 and no counter exists.

Test Plan:
- Reset, then only m0_arvalid with araddr=0x10 -> s_arvalid at next cycle with s_araddr=0x10; m0_arready pulses with s_arready; grant=0; busy=1.
- m0 and m1 request in the same cycle after reset -> m0 granted first. After m0's 4-beat burst (rlast on beat 4), m1 is granted in the first IDLE cycle and s_araddr = m1_araddr.
- Both masters request continuously for 4 bursts -> grants alternate 0,1,0,1. No beat reaches the non-granted master (its rvalid stays 0).
- In DATA, drive m0_rready=0 for 3 cycles with s_rvalid=1 -> s_rready=0 and the beat is held. Releasing rready completes the beat; beat count is unchanged (no duplicates).
- Assert rst during beat 2 of a burst -> next cycle busy=0, s_rready=0, grant=1. A new m1 request is served normally.
- With AXI_RD_ARB_RLAST_CHK_EN and BURST_LEN=4, slave asserts rlast on beat 2 -> err_rlast=1 the cycle after and stays 1 until rst. Without the macro, err_rlast stays 0.
